// File: rtl/sim_run_controller.sv
// sim_run_controller: run controller sitting between bench clock/reset and a
// single-cycle processor core. Stretches reset, drives a clock-enable, counts
// executed cycles, detects a halt (PC stable) and enforces a cycle watchdog.
// Optional build macro: RUN_CTRL_STEP_EN adds step_mode/step single-step control.
module sim_run_controller #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned HALT_CYCLES = 4,
    parameter int unsigned MAX_CYCLES  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
`ifdef RUN_CTRL_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic              proc_rst,
    output logic              proc_en,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [1:0]        state,
    output logic              done,
    output logic              timeout,
    output logic [ADDR_W-1:0] halt_pc
);

    localparam int unsigned RW_RAW = $clog2(RST_CYCLES + 1);
    localparam int unsigned RW     = (RW_RAW < 1) ? 1 : RW_RAW;
    localparam int unsigned SW_RAW = $clog2(HALT_CYCLES + 1);
    localparam int unsigned SW     = (SW_RAW < 1) ? 1 : SW_RAW;
    localparam int unsigned CW1    = CNT_W + 1;

    typedef enum logic [1:0] {
        S_RESET_HOLD = 2'd0,
        S_RUN        = 2'd1,
        S_HALTED     = 2'd2,
        S_TIMEOUT    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                proc_rst_q, proc_rst_d;
    logic                proc_en_q, proc_en_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic [ADDR_W-1:0]   halt_pc_q, halt_pc_d;
    logic [RW-1:0]       rst_cnt_q, rst_cnt_d;
    logic [SW-1:0]       stable_cnt_q, stable_cnt_d;
    logic [ADDR_W-1:0]   last_pc_q, last_pc_d;

    logic                run_en_c;
    logic                pc_same_c;
    logic                halt_hit_c;
    logic                timeout_hit_c;

`ifdef RUN_CTRL_STEP_EN
    logic                step_q;

    // Registered copy of step for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= step;
    end

    // In step mode the core is enabled only for the cycle after a step rise.
    always_comb begin
        run_en_c = step_mode ? (step & ~step_q) : 1'b1;
    end
`else
    // Without step control the core runs continuously while in RUN.
    always_comb begin
        run_en_c = 1'b1;
    end
`endif

    // Halt and watchdog conditions evaluated against the current active edge.
    always_comb begin
        pc_same_c     = (pc_in == last_pc_q);
        halt_hit_c    = (HALT_CYCLES != 0) && pc_same_c &&
                        ((32'(stable_cnt_q) + 32'd1) == HALT_CYCLES);
        timeout_hit_c = (MAX_CYCLES != 0) &&
                        ((CW1'(cycle_cnt_q) + CW1'(1)) == CW1'(MAX_CYCLES));
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RESET_HOLD;
            proc_rst_q   <= 1'b1;
            proc_en_q    <= 1'b0;
            cycle_cnt_q  <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            halt_pc_q    <= '0;
            rst_cnt_q    <= '0;
            stable_cnt_q <= '0;
            last_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            proc_rst_q   <= proc_rst_d;
            proc_en_q    <= proc_en_d;
            cycle_cnt_q  <= cycle_cnt_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            halt_pc_q    <= halt_pc_d;
            rst_cnt_q    <= rst_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            last_pc_q    <= last_pc_d;
        end
    end

    // Next-state and output logic; halted/timeout states hold everything.
    always_comb begin
        state_d      = state_q;
        proc_rst_d   = proc_rst_q;
        proc_en_d    = proc_en_q;
        cycle_cnt_d  = cycle_cnt_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        halt_pc_d    = halt_pc_q;
        rst_cnt_d    = rst_cnt_q;
        stable_cnt_d = stable_cnt_q;
        last_pc_d    = last_pc_q;

        unique case (state_q)
            S_RESET_HOLD: begin
                rst_cnt_d    = rst_cnt_q + RW'(1);
                last_pc_d    = pc_in;
                stable_cnt_d = '0;
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                    state_d    = S_RUN;
                    proc_rst_d = 1'b0;
                    proc_en_d  = run_en_c;
                end
            end
            S_RUN: begin
                proc_en_d = run_en_c;
                if (proc_en_q) begin
                    cycle_cnt_d  = (cycle_cnt_q == {CNT_W{1'b1}}) ? cycle_cnt_q
                                                                   : cycle_cnt_q + CNT_W'(1);
                    last_pc_d    = pc_in;
                    stable_cnt_d = pc_same_c ? stable_cnt_q + SW'(1) : '0;
                    if (halt_hit_c) begin
                        state_d   = S_HALTED;
                        done_d    = 1'b1;
                        proc_en_d = 1'b0;
                        halt_pc_d = pc_in;
                    end else if (timeout_hit_c) begin
                        state_d   = S_TIMEOUT;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                        proc_en_d = 1'b0;
                    end
                end
            end
            default: begin
                proc_en_d = 1'b0;
            end
        endcase
    end

    assign proc_rst  = proc_rst_q;
    assign proc_en   = proc_en_q;
    assign cycle_cnt = cycle_cnt_q;
    assign state     = state_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign halt_pc   = halt_pc_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed testbench for sim_run_controller: reset stretch, halt detect,
// watchdog, simultaneous halt/timeout, async mid-run reset and (when
// RUN_CTRL_STEP_EN is defined) single-step control.
module tb_sim_run_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main instance: halt after 4 repeats, watchdog far away.
    logic        rst_a = 1'b1;
    logic [31:0] pc_a  = '0;
    logic        proc_rst_a, proc_en_a, done_a, timeout_a;
    logic [31:0] cnt_a, hpc_a;
    logic [1:0]  state_a;

    // Watchdog instance: halt disabled, limit 10.
    logic        rst_w = 1'b1;
    logic [31:0] pc_w  = '0;
    logic        proc_rst_w, proc_en_w, done_w, timeout_w;
    logic [31:0] cnt_w, hpc_w;
    logic [1:0]  state_w;

    // Simultaneous-condition instances share reset and PC.
    logic        rst_s = 1'b1;
    logic [31:0] pc_s  = '0;
    logic        proc_rst_4, proc_en_4, done_4, timeout_4;
    logic [31:0] cnt_4, hpc_4;
    logic [1:0]  state_4;
    logic        proc_rst_5, proc_en_5, done_5, timeout_5;
    logic [31:0] cnt_5, hpc_5;
    logic [1:0]  state_5;

    logic step_mode_a = 1'b0;
    logic step_a      = 1'b0;
    logic step_off    = 1'b0;

    int unsigned halt_seq [8] = '{0, 4, 8, 12, 12, 12, 12, 12};

    sim_run_controller #(.ADDR_W(32), .CNT_W(32), .RST_CYCLES(2), .HALT_CYCLES(4), .MAX_CYCLES(1000)) u_main (
        .clk(clk), .rst(rst_a), .pc_in(pc_a),
`ifdef RUN_CTRL_STEP_EN
        .step_mode(step_mode_a), .step(step_a),
`endif
        .proc_rst(proc_rst_a), .proc_en(proc_en_a), .cycle_cnt(cnt_a), .state(state_a),
        .done(done_a), .timeout(timeout_a), .halt_pc(hpc_a));

    sim_run_controller #(.ADDR_W(32), .CNT_W(32), .RST_CYCLES(2), .HALT_CYCLES(0), .MAX_CYCLES(10)) u_wd (
        .clk(clk), .rst(rst_w), .pc_in(pc_w),
`ifdef RUN_CTRL_STEP_EN
        .step_mode(step_off), .step(step_off),
`endif
        .proc_rst(proc_rst_w), .proc_en(proc_en_w), .cycle_cnt(cnt_w), .state(state_w),
        .done(done_w), .timeout(timeout_w), .halt_pc(hpc_w));

    sim_run_controller #(.ADDR_W(32), .CNT_W(32), .RST_CYCLES(2), .HALT_CYCLES(4), .MAX_CYCLES(5)) u_sim4 (
        .clk(clk), .rst(rst_s), .pc_in(pc_s),
`ifdef RUN_CTRL_STEP_EN
        .step_mode(step_off), .step(step_off),
`endif
        .proc_rst(proc_rst_4), .proc_en(proc_en_4), .cycle_cnt(cnt_4), .state(state_4),
        .done(done_4), .timeout(timeout_4), .halt_pc(hpc_4));

    sim_run_controller #(.ADDR_W(32), .CNT_W(32), .RST_CYCLES(2), .HALT_CYCLES(5), .MAX_CYCLES(5)) u_sim5 (
        .clk(clk), .rst(rst_s), .pc_in(pc_s),
`ifdef RUN_CTRL_STEP_EN
        .step_mode(step_off), .step(step_off),
`endif
        .proc_rst(proc_rst_5), .proc_en(proc_en_5), .cycle_cnt(cnt_5), .state(state_5),
        .done(done_5), .timeout(timeout_5), .halt_pc(hpc_5));

    // Reset values, then the 2-edge stretch into RUN.
    task automatic test_reset();
        rst_a = 1'b1;
        pc_a  = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (state_a !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_a); end
        checks++; if (proc_rst_a !== 1'b1) begin failures++; $display("FAIL reset_proc_rst got=%0b exp=1", proc_rst_a); end
        checks++; if (proc_en_a !== 1'b0) begin failures++; $display("FAIL reset_proc_en got=%0b exp=0", proc_en_a); end
        checks++; if (cnt_a !== 32'd0) begin failures++; $display("FAIL reset_cycle_cnt got=%0d exp=0", cnt_a); end
        checks++; if ({done_a, timeout_a} !== 2'b00) begin failures++; $display("FAIL reset_done_timeout got=%b exp=00", {done_a, timeout_a}); end
        checks++; if (hpc_a !== 32'd0) begin failures++; $display("FAIL reset_halt_pc got=%0d exp=0", hpc_a); end
        rst_a = 1'b0;
        @(negedge clk);
        checks++; if (proc_rst_a !== 1'b1 || state_a !== 2'd0 || proc_en_a !== 1'b0)
            begin failures++; $display("FAIL stretch_edge1 got rst=%0b st=%0d en=%0b exp rst=1 st=0 en=0", proc_rst_a, state_a, proc_en_a); end
        @(negedge clk);
        checks++; if (proc_rst_a !== 1'b0 || state_a !== 2'd1 || proc_en_a !== 1'b1 || cnt_a !== 32'd0)
            begin failures++; $display("FAIL stretch_edge2 got rst=%0b st=%0d en=%0b cnt=%0d exp rst=0 st=1 en=1 cnt=0", proc_rst_a, state_a, proc_en_a, cnt_a); end
    endtask

    // PC 0,4,8,12 then 12 held: halt on the 8th active edge.
    task automatic test_halt();
        for (int i = 0; i < 8; i++) begin
            pc_a = 32'(halt_seq[i]);
            @(negedge clk);
            if (i == 6) begin
                checks++; if (state_a !== 2'd1 || cnt_a !== 32'd7)
                    begin failures++; $display("FAIL halt_pre got st=%0d cnt=%0d exp st=1 cnt=7", state_a, cnt_a); end
            end
        end
        checks++; if (state_a !== 2'd2) begin failures++; $display("FAIL halt_state got=%0d exp=2", state_a); end
        checks++; if (done_a !== 1'b1 || timeout_a !== 1'b0) begin failures++; $display("FAIL halt_flags got done=%0b to=%0b exp done=1 to=0", done_a, timeout_a); end
        checks++; if (hpc_a !== 32'd12) begin failures++; $display("FAIL halt_pc got=%0d exp=12", hpc_a); end
        checks++; if (cnt_a !== 32'd8 || proc_en_a !== 1'b0) begin failures++; $display("FAIL halt_cnt_en got cnt=%0d en=%0b exp cnt=8 en=0", cnt_a, proc_en_a); end
        pc_a = 32'd40;
        repeat (5) @(negedge clk);
        checks++; if (state_a !== 2'd2 || cnt_a !== 32'd8 || hpc_a !== 32'd12 || proc_rst_a !== 1'b0)
            begin failures++; $display("FAIL halt_hold got st=%0d cnt=%0d hpc=%0d rst=%0b exp st=2 cnt=8 hpc=12 rst=0", state_a, cnt_a, hpc_a, proc_rst_a); end
    endtask

    // Incrementing PC never halts; watchdog fires at 10 and holds.
    task automatic test_watchdog();
        rst_w = 1'b1;
        pc_w  = 32'd0;
        repeat (2) @(negedge clk);
        rst_w = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            pc_w = pc_w + 32'd4;
            @(negedge clk);
            if (i == 8) begin
                checks++; if (state_w !== 2'd1 || cnt_w !== 32'd9)
                    begin failures++; $display("FAIL wd_pre got st=%0d cnt=%0d exp st=1 cnt=9", state_w, cnt_w); end
            end
        end
        checks++; if (state_w !== 2'd3 || timeout_w !== 1'b1 || done_w !== 1'b1)
            begin failures++; $display("FAIL wd_flags got st=%0d to=%0b done=%0b exp st=3 to=1 done=1", state_w, timeout_w, done_w); end
        checks++; if (cnt_w !== 32'd10 || proc_en_w !== 1'b0)
            begin failures++; $display("FAIL wd_cnt_en got cnt=%0d en=%0b exp cnt=10 en=0", cnt_w, proc_en_w); end
        for (int i = 0; i < 20; i++) begin
            pc_w = pc_w + 32'd4;
            @(negedge clk);
        end
        checks++; if (state_w !== 2'd3 || timeout_w !== 1'b1 || done_w !== 1'b1 || cnt_w !== 32'd10 || proc_en_w !== 1'b0 || hpc_w !== 32'd0)
            begin failures++; $display("FAIL wd_hold got st=%0d to=%0b done=%0b cnt=%0d en=%0b hpc=%0d exp st=3 to=1 done=1 cnt=10 en=0 hpc=0",
                                        state_w, timeout_w, done_w, cnt_w, proc_en_w, hpc_w); end
    endtask

    // Constant PC: halt before timeout (HALT=4), and same-edge tie (HALT=5).
    task automatic test_simultaneous();
        rst_s = 1'b1;
        pc_s  = 32'd0;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        repeat (2) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (state_4 !== 2'd2 || timeout_4 !== 1'b0 || done_4 !== 1'b1 || cnt_4 !== 32'd4)
            begin failures++; $display("FAIL sim4 got st=%0d to=%0b done=%0b cnt=%0d exp st=2 to=0 done=1 cnt=4", state_4, timeout_4, done_4, cnt_4); end
        checks++; if (state_5 !== 2'd1 || cnt_5 !== 32'd4)
            begin failures++; $display("FAIL sim5_pre got st=%0d cnt=%0d exp st=1 cnt=4", state_5, cnt_5); end
        @(negedge clk);
        checks++; if (state_5 !== 2'd2 || timeout_5 !== 1'b0 || done_5 !== 1'b1 || cnt_5 !== 32'd5 || hpc_5 !== 32'd0)
            begin failures++; $display("FAIL sim5_tie got st=%0d to=%0b done=%0b cnt=%0d hpc=%0d exp st=2 to=0 done=1 cnt=5 hpc=0",
                                        state_5, timeout_5, done_5, cnt_5, hpc_5); end
        checks++; if (cnt_4 !== 32'd4 || state_4 !== 2'd2)
            begin failures++; $display("FAIL sim4_hold got st=%0d cnt=%0d exp st=2 cnt=4", state_4, cnt_4); end
    endtask

    // Async reset between edges at cycle_cnt=6, then full stretch again.
    task automatic test_mid_run_reset();
        rst_a = 1'b1;
        pc_a  = 32'd0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            pc_a = pc_a + 32'd4;
            @(negedge clk);
        end
        checks++; if (cnt_a !== 32'd6 || state_a !== 2'd1)
            begin failures++; $display("FAIL mid_pre got st=%0d cnt=%0d exp st=1 cnt=6", state_a, cnt_a); end
        #2 rst_a = 1'b1;
        #1;
        checks++; if (proc_rst_a !== 1'b1 || cnt_a !== 32'd0 || state_a !== 2'd0 || proc_en_a !== 1'b0)
            begin failures++; $display("FAIL mid_async got rst=%0b cnt=%0d st=%0d en=%0b exp rst=1 cnt=0 st=0 en=0", proc_rst_a, cnt_a, state_a, proc_en_a); end
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        checks++; if (proc_rst_a !== 1'b1 || state_a !== 2'd0)
            begin failures++; $display("FAIL mid_stretch1 got rst=%0b st=%0d exp rst=1 st=0", proc_rst_a, state_a); end
        @(negedge clk);
        checks++; if (proc_rst_a !== 1'b0 || state_a !== 2'd1 || proc_en_a !== 1'b1 || cnt_a !== 32'd0)
            begin failures++; $display("FAIL mid_stretch2 got rst=%0b st=%0d en=%0b cnt=%0d exp rst=0 st=1 en=1 cnt=0", proc_rst_a, state_a, proc_en_a, cnt_a); end
    endtask

`ifdef RUN_CTRL_STEP_EN
    // Three step pulses give three single enable cycles; a fourth halts.
    task automatic test_step();
        int en_cnt;
        en_cnt      = 0;
        rst_a       = 1'b1;
        pc_a        = 32'd0;
        step_mode_a = 1'b1;
        step_a      = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state_a !== 2'd1 || proc_en_a !== 1'b0)
            begin failures++; $display("FAIL step_entry got st=%0d en=%0b exp st=1 en=0", state_a, proc_en_a); end
        for (int p = 0; p < 3; p++) begin
            step_a = 1'b1;
            @(negedge clk);
            if (proc_en_a === 1'b1) en_cnt++;
            step_a = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (proc_en_a === 1'b1) en_cnt++;
            end
        end
        checks++; if (en_cnt != 3) begin failures++; $display("FAIL step_en_cycles got=%0d exp=3", en_cnt); end
        checks++; if (cnt_a !== 32'd3 || state_a !== 2'd1)
            begin failures++; $display("FAIL step_cnt got cnt=%0d st=%0d exp cnt=3 st=1", cnt_a, state_a); end
        step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state_a !== 2'd2 || cnt_a !== 32'd4 || done_a !== 1'b1)
            begin failures++; $display("FAIL step_halt got st=%0d cnt=%0d done=%0b exp st=2 cnt=4 done=1", state_a, cnt_a, done_a); end
        step_mode_a = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_halt();
        test_watchdog();
        test_simultaneous();
        test_mid_run_reset();
`ifdef RUN_CTRL_STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
- Parametrised run controller for single-cycle processor benches and FPGA bring-up; one instance sits between the top-level clock/reset and the processor core.
- Stretches the incoming reset into a processor reset of RST_CYCLES clocks and drives a clock-enable.
- Counts executed cycles and detects program halt: PC stable for HALT_CYCLES consecutive executed cycles.
- Enforces a MAX_CYCLES watchdog; reports done/timeout/halt PC so the bench ends on status, not fixed delays.

Parameters:
- ADDR_W, 32, PC width.
- CNT_W, 32, cycle counter width.
- RST_CYCLES, 2, clocks of processor reset after rst deasserts; must be >=1.
- HALT_CYCLES, 4, consecutive repeated-PC executed cycles that declare a halt; 0 disables halt detection.
- MAX_CYCLES, 1000, executed-cycle watchdog limit; 0 disables the watchdog.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- pc_in  input  ADDR_W  current processor PC.
- proc_rst  output  1  reset to processor core.
- proc_en  output  1  clock-enable to processor core; registered.
- cycle_cnt  output  CNT_W  executed (enabled) cycles since reset; saturates at all-ones.
- state  output  2  0=RESET_HOLD, 1=RUN, 2=HALTED, 3=TIMEOUT.
- done  output  1  sticky; high in HALTED or TIMEOUT.
- timeout  output  1  sticky; high in TIMEOUT only.
- halt_pc  output  ADDR_W  PC captured on halt.

Behaviour:
- Reset (rst=1, async): state=RESET_HOLD, proc_rst=1, proc_en=0, cycle_cnt=0, done=0, timeout=0, halt_pc=0; internal rst_cnt=0, stable_cnt=0, last_pc=0.
- rst asserted mid-run returns immediately to the reset values above; no status survives.
- RESET_HOLD:
  - rst_cnt increments each edge.
  - last_pc <= pc_in each edge; stable_cnt held at 0.
  - On the edge where rst_cnt==RST_CYCLES-1: state<=RUN, proc_rst<=0, proc_en<=1.
  - Net effect: proc_rst stays high for exactly RST_CYCLES rising edges after rst falls.
- Active edge: a rising edge in RUN with proc_en==1. Only active edges update cycle_cnt, last_pc and stable_cnt.
- At each active edge:
  - cycle_cnt <= cycle_cnt+1, saturating.
  - last_pc <= pc_in.
  - stable_cnt <= (pc_in==last_pc) ? stable_cnt+1 : 0.
  - Halt condition: HALT_CYCLES!=0, pc_in==last_pc and stable_cnt+1==HALT_CYCLES.
  - Timeout condition: MAX_CYCLES!=0 and cycle_cnt+1==MAX_CYCLES.
- On halt: state<=HALTED, done<=1, proc_en<=0, halt_pc<=pc_in.
- On timeout: state<=TIMEOUT, done<=1, timeout<=1, proc_en<=0.
- If halt and timeout occur on the same edge, halt wins; timeout stays 0.
- HALTED/TIMEOUT are terminal until rst. All outputs hold; proc_rst stays 0; cycle_cnt frozen.
- Edges where proc_en==0 in RUN (step mode only) change nothing.
- Widths: stable_cnt is wide enough for HALT_CYCLES. PC compare is full ADDR_W equality.

Optional Feature:
- Macro: RUN_CTRL_STEP_EN.
- Defined:
  - Adds inputs step_mode (1) and step (1).
  - In RUN with step_mode=1: proc_en is 1 for exactly one cycle after each rising edge of step (edge detected on registered step), otherwise 0.
  - step_mode=0 gives continuous proc_en=1.
  - Counters advance only on active edges as above.
  - step is ignored outside RUN.
- Undefined: the ports are absent and proc_en is always 1 throughout RUN.

Test Plan:
- Reset stretch: RST_CYCLES=2, rst high 3 cycles then low -> proc_rst high through 2 rising edges after deassert, then 0; proc_en=1 and state=1 on the same edge.
- Halt detect: HALT_CYCLES=4, pc_in steps 0,4,8,12 then holds 12 -> state=2, done=1, halt_pc=12, proc_en=0 on the 4th repeated-12 active edge; cycle_cnt=8; timeout=0.
- Watchdog: MAX_CYCLES=10, pc_in increments by 4 every cycle -> state=3, timeout=1, done=1, cycle_cnt=10, proc_en=0; outputs stable for 20 more cycles.
- Simultaneous: MAX_CYCLES=5, HALT_CYCLES=4, pc_in=0 constant from RUN entry -> halt reached at cycle_cnt 4 before timeout at 5; verify state=2, timeout=0. Repeat with HALT_CYCLES=5 -> both conditions on the same edge, state=2, timeout=0.
- Mid-run reset: assert rst asynchronously (between edges) at cycle_cnt=6 -> proc_rst=1, cycle_cnt=0, state=0 immediately without waiting for a clock edge; full reset stretch repeats after release.
- RUN_CTRL_STEP_EN: step_mode=1, three step pulses 5 cycles apart -> proc_en high exactly 3 single cycles; cycle_cnt=3; halt/timeout counters unaffected by idle cycles.
